// File: rtl/rr_shift_arbiter_pkg.sv
// Shared types and constants for the round-robin shift arbiter.
package rr_shift_arbiter_pkg;

    localparam int unsigned RR_ARB_STALL_W   = 8;
    localparam logic [7:0]  RR_ARB_STALL_MAX = 8'd255;

    typedef enum logic {
        RR_IDLE  = 1'b0,
        RR_GRANT = 1'b1
    } rr_arb_state_t;

endpackage : rr_shift_arbiter_pkg

// File: rtl/barrel_shift.sv
// Combinational barrel rotator; WIDTH must be a power of two so index math wraps naturally.
module barrel_shift #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SHIFT_W      = $clog2(WIDTH),
    parameter bit          ROTATE_RIGHT = 1'b1
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHIFT_W-1:0] nshifts,
    output logic [WIDTH-1:0]   data_out_c
);

    logic [SHIFT_W-1:0] src;

    // Each output bit picks its source bit; right rotation maps out[i] = in[i + n].
    always_comb begin
        data_out_c = '0;
        src        = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ROTATE_RIGHT) begin
                src = SHIFT_W'(i) + nshifts;
            end else begin
                src = SHIFT_W'(i) - nshifts;
            end
            data_out_c[i] = data_in[src];
        end
    end

endmodule : barrel_shift

// File: rtl/rr_shift_arbiter.sv
// Round-robin arbiter with registered one-hot grant held under valid/ready.
// Optional feature: define RR_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module rr_shift_arbiter
    import rr_shift_arbiter_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             in_ready,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
`ifdef RR_ARB_STALL_CNT_EN
    ,
    output logic [RR_ARB_STALL_W-1:0] stall_cnt
`endif
);

    rr_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

    logic             accept;
    logic             has_req;
    logic [IDX_W-1:0] ptr_next;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] lowest_k;
    logic [IDX_W-1:0] winner;

    // Pointer for the upcoming selection: one past the accepted index, else unchanged.
    always_comb begin
        accept   = gnt_valid_q & in_ready;
        has_req  = |req;
        ptr_next = accept ? (gnt_idx_q + IDX_W'(1)) : ptr_q;
    end

    barrel_shift #(
        .WIDTH        (N),
        .SHIFT_W      (IDX_W),
        .ROTATE_RIGHT (1'b1)
    ) u_rot (
        .data_in    (req),
        .nshifts    (ptr_next),
        .data_out_c (req_rot)
    );

    // Lowest set bit of the rotated request, mapped back to an absolute index.
    always_comb begin
        lowest_k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                lowest_k = IDX_W'(i);
            end
        end
        winner = ptr_next + lowest_k;
    end

    // Next-state and grant-register logic; grant is frozen until accepted.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;

        unique case (state_q)
            RR_IDLE: begin
                if (has_req) begin
                    gnt_d       = N'(1) << winner;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = winner;
                    state_d     = RR_GRANT;
                end
            end
            RR_GRANT: begin
                if (accept) begin
                    ptr_d = ptr_next;
                    if (has_req) begin
                        gnt_d     = N'(1) << winner;
                        gnt_idx_d = winner;
                    end else begin
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                        gnt_idx_d   = '0;
                        state_d     = RR_IDLE;
                    end
                end
            end
            default: begin
                state_d = RR_IDLE;
            end
        endcase
    end

    // State and grant registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RR_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

`ifdef RR_ARB_STALL_CNT_EN
    logic [RR_ARB_STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles a grant waits on the downstream; cleared on accept.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            stall_cnt_d = '0;
        end else if (gnt_valid_q && (stall_cnt_q != RR_ARB_STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + RR_ARB_STALL_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : rr_shift_arbiter

// File: tb/tb_rr_shift_arbiter.sv
// Scoreboard bench for rr_shift_arbiter; build with RR_ARB_STALL_CNT_EN to cover stall_cnt.
module tb_rr_shift_arbiter;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    logic             clock;
    logic             reset;
    logic [N-1:0]     req;
    logic             in_ready;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
`ifdef RR_ARB_STALL_CNT_EN
    logic [7:0]       stall_cnt;
`endif

    rr_shift_arbiter #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in_ready  (in_ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
`ifdef RR_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       valid;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic [7:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    int   m_ptr   = 0;
    int   m_idx   = 0;
    bit   m_valid = 1'b0;
    int   m_stall = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find_first(input logic [7:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return 0;
    endfunction

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic [7:0] r, input logic rdy, input logic rst);
        exp_t e;
        bit   acc;
        int   pn;
        int   ns;
        req      = r;
        in_ready = rdy;
        reset    = rst;
        if (!rst && m_valid && !rdy) check_val("proto_req_held", 32'(r[m_idx]), 32'd1);
        if (rst) begin
            m_ptr = 0; m_idx = 0; m_valid = 1'b0; m_stall = 0;
        end else begin
            acc = m_valid && rdy;
            pn  = acc ? (m_idx + 1) % N : m_ptr;
            ns  = m_stall;
            if (acc) ns = 0;
            else if (m_valid && m_stall < 255) ns = m_stall + 1;
            if (!m_valid) begin
                if (r != 8'h00) begin
                    m_valid = 1'b1;
                    m_idx   = find_first(r, pn);
                end
            end else if (acc) begin
                m_ptr = pn;
                if (r != 8'h00) m_idx = find_first(r, pn);
                else begin
                    m_valid = 1'b0;
                    m_idx   = 0;
                end
            end
            m_stall = ns;
        end
        e.valid = m_valid;
        e.gnt   = m_valid ? 8'(1 << m_idx) : 8'h00;
        e.idx   = 3'(m_idx);
        e.stall = 8'(m_stall);
        exp_q.push_back(e);

        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("gnt", 32'(gnt), 32'(e.gnt));
            check_val("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            check_val("gnt_idx", 32'(gnt_idx), 32'(e.idx));
`ifdef RR_ARB_STALL_CNT_EN
            check_val("stall_cnt", 32'(stall_cnt), 32'(e.stall));
`endif
        end
    endtask

    initial begin
        int   exp_seq [10];
        logic [7:0] r;
        logic rdy;
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

        // Reset values
        step(8'h00, 1'b0, 1'b1);
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_valid", 32'(gnt_valid), 32'h0);
        check_val("rst_idx", 32'(gnt_idx), 32'h0);

        // Wrap of pointer from 7 back to 0
        step(8'h81, 1'b1, 1'b0);
        check_val("wrap_g0", 32'(gnt), 32'h01);
        step(8'h81, 1'b1, 1'b0);
        check_val("wrap_g7", 32'(gnt), 32'h80);
        check_val("wrap_i7", 32'(gnt_idx), 32'd7);
        step(8'h81, 1'b1, 1'b0);
        check_val("wrap_g0b", 32'(gnt), 32'h01);
        step(8'h00, 1'b1, 1'b0);
        check_val("drain_idle", 32'(gnt_valid), 32'h0);

        // Held grant ignores new higher-priority request
        step(8'h10, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b0);
        step(8'h12, 1'b0, 1'b0);
        step(8'h12, 1'b0, 1'b0);
        check_val("hold_gnt", 32'(gnt), 32'h10);
        check_val("hold_valid", 32'(gnt_valid), 32'h1);
        step(8'h12, 1'b1, 1'b0);
        check_val("hold_next", 32'(gnt), 32'h02);
        step(8'h00, 1'b1, 1'b0);

        // Full request back-to-back from a fresh pointer
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 1'b1, 1'b0);
            check_val("b2b_idx", 32'(gnt_idx), 32'(exp_seq[i]));
        end
        step(8'h00, 1'b1, 1'b0);

        // Accepted requester becomes lowest priority
        step(8'h40, 1'b0, 1'b0);
        check_val("lp_i6", 32'(gnt_idx), 32'd6);
        step(8'h41, 1'b1, 1'b0);
        check_val("lp_i0", 32'(gnt_idx), 32'd0);
        step(8'h41, 1'b1, 1'b0);
        check_val("lp_i6b", 32'(gnt_idx), 32'd6);
        step(8'h00, 1'b1, 1'b0);
        check_val("lp_idle", 32'(gnt_valid), 32'h0);
        step(8'h00, 1'b1, 1'b0);

        // Reset during a stalled grant, reset dominates accept
        step(8'h08, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        check_val("rg_gnt", 32'(gnt), 32'h08);
        step(8'h08, 1'b1, 1'b1);
        check_val("rg_rst_gnt", 32'(gnt), 32'h0);
        check_val("rg_rst_valid", 32'(gnt_valid), 32'h0);
        check_val("rg_rst_idx", 32'(gnt_idx), 32'h0);
        step(8'h08, 1'b0, 1'b0);
        check_val("rg_regrant", 32'(gnt), 32'h08);
        step(8'h00, 1'b1, 1'b0);

`ifdef RR_ARB_STALL_CNT_EN
        // Stall counter saturation and clear
        step(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(8'h01, 1'b0, 1'b0);
        check_val("stall_sat", 32'(stall_cnt), 32'd255);
        step(8'h00, 1'b1, 1'b0);
        check_val("stall_clr", 32'(stall_cnt), 32'd0);
`endif

        // Random legal traffic
        for (int i = 0; i < 300; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            r   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            if (m_valid && !rdy) r[m_idx] = 1'b1;
            step(r, rdy, ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_shift_arbiter

// File: doc/rr_shift_arbiter.md
# rr_shift_arbiter

Round-robin arbiter that shares one downstream resource (issue slot, CDB port, functional unit) among N requesters. It rotates the request vector by a priority pointer through a `barrel_shift` instance, selects the lowest set bit, and maps the winner back to an absolute index. The grant is registered and held under a valid/ready handshake until accepted. Used wherever the pipeline needs fair, starvation-free selection.

## Interface
- `N`, default 8: number of requesters; power of two, ≥ 2.
- `IDX_W`, default `$clog2(N)`: width of index and pointer; derived, never overridden.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N  request bit per requester; a requester holds its bit until granted and accepted.
- `in_ready`  in  1  downstream accepts the current grant this cycle.
- `gnt`  out  N  registered one-hot grant; all zero when `gnt_valid`=0.
- `gnt_valid`  out  1  a grant is presented.
- `gnt_idx`  out  IDX_W  binary index of `gnt`; 0 when `gnt_valid`=0.
- `stall_cnt`  out  8  present only with `RR_ARB_STALL_CNT_EN`.

## Operation
- State: `ptr` (IDX_W, highest-priority index), grant register, two-state FSM IDLE/GRANT.
- accept = `gnt_valid & in_ready`.
- `ptr_next` = accept ? (`gnt_idx`+1) mod N : `ptr`. Wrap from N−1 to 0 is natural IDX_W overflow.
- Selection (combinational, on `req` and `ptr_next`): rotate `req` right by `ptr_next`, so rotated bit 0 = `req[ptr_next]`. k = lowest set bit. winner = (`ptr_next`+k) mod N.
- IDLE: `gnt_valid`=0. If `|req` → load winner, go to GRANT. Otherwise stay.
- GRANT, no accept: `gnt`, `gnt_idx`, `ptr` frozen. `req` changes, including new higher-priority requests, are ignored.
- GRANT, accept: `ptr`←`ptr_next`. If `|req` → load new winner, stay in GRANT. Else → IDLE, clear `gnt`/`gnt_idx`.
- The just-accepted requester, if still requesting, is lowest priority in the next selection.
- `in_ready` high in IDLE has no effect.
- Withdrawing `req` while granted and unaccepted is illegal. The grant is held regardless. The bench flags it as a protocol error.

## Timing
- Reset values: `ptr`=0, FSM=IDLE, `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `stall_cnt`=0.
- Latency: `req` asserted in cycle t with arbiter IDLE → grant visible in cycle t+1.
- Back-to-back: with `in_ready` held high and requests pending, a new grant appears every cycle.
- Outputs come straight from flops; there is no combinational path from `req` or `in_ready` to any output.
- Reset during GRANT: the next cycle shows all reset values. The pending grant is dropped and `ptr` returns to 0.
- Reset dominates accept and request in the same cycle.

## Configuration
- `RR_ARB_STALL_CNT_EN` defined: adds `stall_cnt` output.
  - Increments each cycle with `gnt_valid & ~in_ready`.
  - Saturates at 255.
  - Clears to 0 on accept and on reset.
  - Holds its value in IDLE.
- `RR_ARB_STALL_CNT_EN` undefined: port and counter are absent. Arbitration behaviour is identical.

## Structure
- Shared package holds:
  - `RR_ARB_STALL_MAX` = 8'd255.
  - FSM enum `rr_arb_state_t {RR_IDLE, RR_GRANT}`.
- One sub-module: the existing `barrel_shift`, instantiated with N, configured for right rotation, `nshifts`=`ptr_next`.
- Priority encoder and index-to-one-hot conversion stay inline.

## Test plan
- Reset, then `req`=8'h81, `in_ready`=1 → t+1: `gnt`=8'h01, idx 0. Then `gnt`=8'h80, idx 7. Then `gnt`=8'h01 again (`ptr` wrapped to 0).
- `req`=8'h10, `in_ready`=0 for 4 cycles, with 8'h02 added at cycle 2 → `gnt`=8'h10 stable and `gnt_valid`=1 throughout. After accept → `gnt`=8'h02.
- `req`=8'hFF, `in_ready`=1 for 10 cycles → `gnt_idx` sequence 0,1,2,…,7,0,1.
- Grant idx 6 accepted, then `req`=8'h41 → next `gnt_idx`=0 (`ptr`=7, bit 7 clear). Then `gnt_idx`=6. Then IDLE once `req`=0.
- Stalled grant on idx 3, `reset` pulsed one cycle → next cycle `gnt`=0, `gnt_valid`=0, `gnt_idx`=0. With `req`=8'h08 still high, `gnt`=8'h08 one cycle after reset drops.
- With `RR_ARB_STALL_CNT_EN`: 300 stall cycles → `stall_cnt` reaches 255 and holds. Accept → 0 on the next cycle.
